// File: rtl/serial_link_pkg.sv
// Shared definitions for the framed serial link: FSM encoding, default sync
// pattern, idle-pattern rule and checksum fold. The receiver imports this too.
package serial_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_CSUM = 2'd3
  } tx_state_t;

  localparam int          DEFAULT_SYNC_W    = 16;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hF0C3;

  // The idle line alternates every bit so the far end always sees edges.
  function automatic logic idle_next_bit(input logic prev);
    return ~prev;
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Free-running bit-period divider: tick is high on the last clock of every
// CLKS_PER_BIT-clock bit period (always high when CLKS_PER_BIT is 1).
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [7:0] count;

  assign tick = (count == 8'(CLKS_PER_BIT - 1));

  // Divider counter, wraps to zero on the tick clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Framing serializer: sync word, payload bytes, XOR checksum, MSB first, with a
// toggling idle pattern between frames and a one-entry input holding register.
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 4,
  parameter int                SYNC_W       = DEFAULT_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD    = SYNC_W'(DEFAULT_SYNC_WORD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       underrun
);

  localparam int CNT_W = (SYNC_W > 8) ? $clog2(SYNC_W) + 1 : 4;

  tx_state_t         state, state_next;
  logic [7:0]        shifter, shifter_next;
  logic [SYNC_W-1:0] sync_sr, sync_sr_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [7:0]        csum, csum_next;
  logic              cur_last, cur_last_next;
  logic              serial_next, busy_next, underrun_next;
  logic [7:0]        hold_data;
  logic              hold_last, hold_full;
  logic              load;
  logic              tick;

  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign s_ready = ~hold_full;

  // Frame sequencing; busy tracks whether the bit now on the line belongs to a frame.
  always_comb begin
    state_next    = state;
    serial_next   = serial_out;
    busy_next     = busy;
    underrun_next = 1'b0;
    shifter_next  = shifter;
    sync_sr_next  = sync_sr;
    cnt_next      = cnt;
    csum_next     = csum;
    cur_last_next = cur_last;
    load          = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (hold_full) begin
            serial_next  = SYNC_WORD[SYNC_W-1];
            sync_sr_next = {SYNC_WORD[SYNC_W-2:0], 1'b0};
            cnt_next     = {CNT_W{1'b0}};
            busy_next    = 1'b1;
            state_next   = ST_SYNC;
          end else begin
            serial_next = idle_next_bit(serial_out);
            busy_next   = 1'b0;
          end
        end
        ST_SYNC: begin
          serial_next  = sync_sr[SYNC_W-1];
          sync_sr_next = {sync_sr[SYNC_W-2:0], 1'b0};
          if (cnt == CNT_W'(SYNC_W - 2)) begin
            load          = 1'b1;
            shifter_next  = hold_data;
            cur_last_next = hold_last;
            csum_next     = csum_update(8'h00, hold_data);
            cnt_next      = {CNT_W{1'b0}};
            state_next    = ST_DATA;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          serial_next  = shifter[7];
          shifter_next = {shifter[6:0], 1'b0};
          if (cnt == CNT_W'(7)) begin
            cnt_next = {CNT_W{1'b0}};
            // csum already folds in the byte now finishing, so it is the final value.
            if (cur_last) begin
              shifter_next = csum;
              state_next   = ST_CSUM;
            end else if (hold_full) begin
              load          = 1'b1;
              shifter_next  = hold_data;
              cur_last_next = hold_last;
              csum_next     = csum_update(csum, hold_data);
            end else begin
              underrun_next = 1'b1;
              state_next    = ST_IDLE;
            end
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        ST_CSUM: begin
          if (cnt == CNT_W'(8)) begin
            serial_next = idle_next_bit(serial_out);
            busy_next   = 1'b0;
            cnt_next    = {CNT_W{1'b0}};
            state_next  = ST_IDLE;
          end else begin
            serial_next  = shifter[7];
            shifter_next = {shifter[6:0], 1'b0};
            cnt_next     = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end else begin
      load = 1'b0;
    end
  end

  // Line, FSM and shifter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      shifter    <= 8'h00;
      sync_sr    <= {SYNC_W{1'b0}};
      cnt        <= {CNT_W{1'b0}};
      csum       <= 8'h00;
      cur_last   <= 1'b0;
    end else begin
      state      <= state_next;
      serial_out <= serial_next;
      busy       <= busy_next;
      underrun   <= underrun_next;
      shifter    <= shifter_next;
      sync_sr    <= sync_sr_next;
      cnt        <= cnt_next;
      csum       <= csum_next;
      cur_last   <= cur_last_next;
    end
  end

  // One-entry holding register; it can only fill while empty and only drain while full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
    end else if (s_valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= s_data;
      hold_last <= s_last;
    end else if (load) begin
      hold_full <= 1'b0;
    end else begin
      hold_full <= hold_full;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: instance 0 runs at 1 clk/bit, instance 1 at 4 clk/bit,
// each checked every cycle against a bit-stream model of the framing rules.
module tb_serial_frame_tx;

  localparam logic [15:0] SYNC = 16'hF0C3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0][7:0] s_data_v = '0;
  logic [1:0]      s_valid_v = 2'b00;
  logic [1:0]      s_last_v = 2'b00;
  wire  [1:0]      s_ready_v, serial_out_v, busy_v, underrun_v;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int CPB = (k == 0) ? 1 : 4;

    serial_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .s_data     (s_data_v[k]),
      .s_valid    (s_valid_v[k]),
      .s_last     (s_last_v[k]),
      .s_ready    (s_ready_v[k]),
      .serial_out (serial_out_v[k]),
      .busy       (busy_v[k]),
      .underrun   (underrun_v[k])
    );

    // Model: a queue of frame bits still to be sent; the unit kinds are
    // 0 = none, 1 = sync, 2 = data byte, 3 = checksum.
    bit         q[$];
    int         kind;
    bit         m_line, m_busy, m_und, force_idle, cur_last;
    bit         mh_valid, mh_last;
    logic [7:0] mh_data, m_csum;
    int         edge_n;
    int         busy_cnt = 0;
    int         und_cnt  = 0;
    logic [63:0] cap = '0;

    task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) q.push_back(b[i]);
    endtask

    task automatic unit_end();
      if (kind == 3) begin
        force_idle = 1'b1;
        kind = 0;
      end else if (kind == 2 && cur_last) begin
        push_byte(m_csum);
        kind = 3;
      end else if (mh_valid) begin
        push_byte(mh_data);
        m_csum   = m_csum ^ mh_data;
        cur_last = mh_last;
        mh_valid = 1'b0;
        kind = 2;
      end else begin
        m_und = 1'b1;
        kind = 0;
      end
    endtask

    task automatic emit();
      m_line = q.pop_front();
      m_busy = 1'b1;
      if (q.size() == 0) unit_end();
    endtask

    task automatic slot();
      if (q.size() != 0) begin
        emit();
      end else if (force_idle || !mh_valid) begin
        m_line = ~m_line;
        m_busy = 1'b0;
        force_idle = 1'b0;
      end else begin
        for (int i = 15; i >= 0; i--) q.push_back(SYNC[i]);
        kind   = 1;
        m_csum = 8'h00;
        emit();
      end
    endtask

    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        kind = 0; m_line = 0; m_busy = 0; m_und = 0; force_idle = 0; cur_last = 0;
        mh_valid = 0; mh_last = 0; mh_data = 8'h00; m_csum = 8'h00; edge_n = 0;
      end else begin
        bit acc;
        logic [7:0] acc_d;
        bit acc_l;
        acc   = s_valid_v[k] && !mh_valid;
        acc_d = s_data_v[k];
        acc_l = s_last_v[k];
        m_und = 1'b0;
        if ((edge_n % CPB) == CPB - 1) slot();
        edge_n++;
        if (acc) begin
          mh_valid = 1'b1; mh_data = acc_d; mh_last = acc_l;
        end
      end
    end

    initial forever begin
      @(negedge clk);
      if (!rst) begin
        check("serial_out", k, 64'(serial_out_v[k]), 64'(m_line));
        check("busy", k, 64'(busy_v[k]), 64'(m_busy));
        check("underrun", k, 64'(underrun_v[k]), 64'(m_und));
        check("s_ready", k, 64'(s_ready_v[k]), 64'(!mh_valid));
        if (busy_v[k]) begin
          busy_cnt++;
          cap = {cap[62:0], serial_out_v[k]};
        end
        if (underrun_v[k]) und_cnt++;
      end
    end
  end

  task automatic send_byte(input int k, input logic [7:0] d, input logic l);
    int n;
    s_data_v[k]  = d;
    s_last_v[k]  = l;
    s_valid_v[k] = 1'b1;
    n = 0;
    while (!s_ready_v[k] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      $display("FAIL accept_timeout[%0d]: s_ready stayed %0b for %0d cycles, required 1", k, s_ready_v[k], n);
    end
    @(negedge clk);
    s_valid_v[k] = 1'b0;
  endtask

  task automatic rand_frames(input int k, input int nframes, input int maxgap);
    int len, gap;
    for (int f = 0; f < nframes; f++) begin
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) begin
        gap = ($urandom_range(0, 7) == 0) ? $urandom_range(0, maxgap * 4) : $urandom_range(0, maxgap);
        repeat (gap) @(negedge clk);
        send_byte(k, 8'($urandom), (b == len - 1));
      end
    end
    repeat (300) @(negedge clk);
  endtask

  task automatic wait_busy0(input int target, input string name);
    int n;
    n = 0;
    while (g[0].busy_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL %s: busy count %0d, required at least %0d", name, g[0].busy_cnt, target);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int k = 0; k < 2; k++) begin
      check({name, "_serial_out"}, k, 64'(serial_out_v[k]), 64'd0);
      check({name, "_s_ready"}, k, 64'(s_ready_v[k]), 64'd1);
      check({name, "_busy"}, k, 64'(busy_v[k]), 64'd0);
      check({name, "_underrun"}, k, 64'(underrun_v[k]), 64'd0);
    end
  endtask

  initial begin
    int b0, u0;
    bit exp_idle [4];
    exp_idle = '{1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Idle pattern from the first clock after release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_reset", i, 64'(serial_out_v[0]), 64'(exp_idle[i]));
    end
    repeat (4) @(negedge clk);

    // Two-byte frame at 1 clk/bit.
    b0 = g[0].busy_cnt; u0 = g[0].und_cnt;
    send_byte(0, 8'hA5, 1'b0);
    send_byte(0, 8'h3C, 1'b1);
    repeat (50) @(negedge clk);
    check("frame_busy_clocks", 0, 64'(g[0].busy_cnt - b0), 64'd40);
    check("frame_bits", 0, {24'h0, g[0].cap[39:0]}, 64'hF0C3A53C99);
    check("frame_no_underrun", 0, 64'(g[0].und_cnt - u0), 64'd0);

    // Underrun after one byte, then a clean single-byte frame.
    b0 = g[0].busy_cnt; u0 = g[0].und_cnt;
    send_byte(0, 8'h11, 1'b0);
    repeat (40) @(negedge clk);
    check("underrun_pulses", 0, 64'(g[0].und_cnt - u0), 64'd1);
    check("underrun_busy_clocks", 0, 64'(g[0].busy_cnt - b0), 64'd24);
    check("underrun_bits", 0, {40'h0, g[0].cap[23:0]}, 64'hF0C311);
    b0 = g[0].busy_cnt;
    send_byte(0, 8'h42, 1'b1);
    repeat (40) @(negedge clk);
    check("after_underrun_bits", 0, {32'h0, g[0].cap[31:0]}, 64'hF0C34242);
    check("after_underrun_busy", 0, 64'(g[0].busy_cnt - b0), 64'd32);

    // Back-to-back: second frame offered during the first frame's checksum.
    b0 = g[0].busy_cnt; u0 = g[0].und_cnt;
    send_byte(0, 8'h5A, 1'b1);
    wait_busy0(b0 + 26, "b2b_wait_csum");
    send_byte(0, 8'h77, 1'b1);
    repeat (50) @(negedge clk);
    check("b2b_busy_clocks", 0, 64'(g[0].busy_cnt - b0), 64'd64);
    check("b2b_bits", 0, g[0].cap, 64'hF0C35A5AF0C37777);
    check("b2b_no_underrun", 0, 64'(g[0].und_cnt - u0), 64'd0);

    // Single zero byte at 4 clk/bit.
    b0 = g[1].busy_cnt; u0 = g[1].und_cnt;
    send_byte(1, 8'h00, 1'b1);
    repeat (160) @(negedge clk);
    check("cpb4_busy_clocks", 1, 64'(g[1].busy_cnt - b0), 64'd128);
    check("cpb4_no_underrun", 1, 64'(g[1].und_cnt - u0), 64'd0);

    // Asynchronous reset in the middle of a data byte, with a byte still held.
    b0 = g[0].busy_cnt;
    send_byte(0, 8'hAA, 1'b0);
    send_byte(0, 8'hBB, 1'b0);
    wait_busy0(b0 + 20, "reset_wait_data");
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    b0 = g[0].busy_cnt; u0 = g[0].und_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_after_midreset", i, 64'(serial_out_v[0]), 64'(exp_idle[i]));
    end
    repeat (40) @(negedge clk);
    check("midreset_no_underrun", 0, 64'(g[0].und_cnt - u0), 64'd0);
    check("midreset_stays_idle", 0, 64'(g[0].busy_cnt - b0), 64'd0);

    // Randomised traffic on both instances, checked cycle by cycle.
    rand_frames(0, 25, 6);
    rand_frames(1, 15, 30);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal;
  end

endmodule
